// File: rtl/display_arbiter_if.sv
// Bundle between the requesters and the display arbiter. The master side owns
// the requests and the values to show. The slave side is the arbiter, which
// returns the grant and the registered display value.
interface display_arbiter_if;
   logic [3:0]  req;
   logic [63:0] values;
   logic [3:0]  grant;
   logic [1:0]  owner;
   logic        busy;
   logic [15:0] number;
   logic        switch_pulse;

   modport master (
      output req, values,
      input  grant, owner, busy, number, switch_pulse
   );

   modport slave (
      input  req, values,
      output grant, owner, busy, number, switch_pulse
   );
endinterface

// File: rtl/display_arbiter.sv
// Round-robin owner selection for the shared 4-digit seven-segment display.
// Each new owner keeps the display for at least DWELL_CYCLES clocks, so its
// value stays readable before the display rotates to the next requester.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | nobody owns the display; number shows IDLE_VALUE
// S_HOLD  | owner is inside its minimum dwell; other requests are ignored
// S_SHARE | dwell is over; owner keeps the display until another requester asks
module display_arbiter #(
   parameter int unsigned DWELL_CYCLES = 50000000,
   parameter int unsigned CNT_W        = 26,
   parameter logic [15:0] IDLE_VALUE   = 16'h0000
) (
   input logic              clk,
   input logic              rst,
   display_arbiter_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SHARE} state_t;

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       last_q, last_d;
   logic [1:0]       owner_q, owner_d;
   logic [3:0]       grant_q, grant_d;
   logic [15:0]      number_q, number_d;
   logic             pulse_q, pulse_d;

   logic [3:0]  own_bit;
   logic [3:0]  others;
   logic [3:0]  mask;
   logic [1:0]  win;
   logic [15:0] cur_val;
   logic        do_grant;
   logic        do_idle;

   // First requester in mask after position last, wrapping around; the
   // caller only uses the result when mask is non-zero.
   function automatic logic [1:0] rr_pick(input logic [3:0] m, input logic [1:0] last);
      logic [1:0] idx;
      logic [1:0] w;
      logic       found;
      w     = last;
      found = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         idx = last + 2'(i);
         if (!found && m[idx]) begin
            w     = idx;
            found = 1'b1;
         end
      end
      return w;
   endfunction

   // State register and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         last_q   <= 2'd3;
         owner_q  <= 2'd0;
         grant_q  <= 4'b0000;
         number_q <= IDLE_VALUE;
         pulse_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         owner_q  <= owner_d;
         grant_q  <= grant_d;
         number_q <= number_d;
         pulse_q  <= pulse_d;
      end
   end

   // Next-state logic. A dropped owner hands over on the same edge when
   // anyone else is waiting, so a release never produces a second pulse.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      owner_d  = owner_q;
      grant_d  = grant_q;
      number_d = number_q;
      pulse_d  = 1'b0;
      do_grant = 1'b0;
      do_idle  = 1'b0;
      own_bit  = 4'b0001 << owner_q;
      others   = bus.req & ~own_bit;
      mask     = bus.req;
      cur_val  = bus.values[{owner_q, 4'b0000} +: 16];

      case (state_q)
         S_IDLE: begin
            if (|bus.req) do_grant = 1'b1;
            else          number_d = IDLE_VALUE;
         end
         S_HOLD: begin
            if (!bus.req[owner_q]) begin
               if (|others) do_grant = 1'b1;
               else         do_idle  = 1'b1;
            end else begin
               number_d = cur_val;
               if (cnt_q == '0) state_d = S_SHARE;
               else             cnt_d   = cnt_q - CNT_W'(1);
            end
         end
         S_SHARE: begin
            if (!bus.req[owner_q]) begin
               if (|others) do_grant = 1'b1;
               else         do_idle  = 1'b1;
            end else if (|others) begin
               do_grant = 1'b1;
               mask     = others;
            end else begin
               number_d = cur_val;
            end
         end
         default: state_d = S_IDLE;
      endcase

      win = rr_pick(mask, last_q);

      if (do_grant) begin
         state_d  = S_HOLD;
         cnt_d    = RELOAD;
         last_d   = win;
         owner_d  = win;
         grant_d  = 4'b0001 << win;
         number_d = bus.values[{win, 4'b0000} +: 16];
         pulse_d  = 1'b1;
      end
      if (do_idle) begin
         state_d  = S_IDLE;
         grant_d  = 4'b0000;
         number_d = IDLE_VALUE;
      end
   end

   assign bus.grant        = grant_q;
   assign bus.owner        = owner_q;
   assign bus.busy         = |grant_q;
   assign bus.number       = number_q;
   assign bus.switch_pulse = pulse_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter with a short dwell. The reference model tracks the
// owner and the number of edges since its grant. It switches owners only when
// the owner drops its request, or when the owner has held the display for more
// than DWELL edges and someone else is waiting.
module tb_display_arbiter;
   localparam int          DWELL = 4;
   localparam logic [15:0] IDLE  = 16'h0000;

   logic clk;
   logic rst;
   display_arbiter_if bus();

   display_arbiter #(
      .DWELL_CYCLES(DWELL),
      .CNT_W       (4),
      .IDLE_VALUE  (IDLE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   int          m_owner;
   int          m_last;
   int          m_age;
   bit          m_busy;
   logic [15:0] m_number;
   bit          m_pulse;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, required earlier $finish");
      $fatal(1);
   end

   task automatic m_take(input logic [3:0] m);
      int  idx;
      bit  found;
      found = 0;
      for (int i = 1; i <= 4; i++) begin
         idx = (m_last + i) % 4;
         if (!found && m[idx]) begin
            found   = 1;
            m_owner = idx;
         end
      end
      m_last   = m_owner;
      m_busy   = 1;
      m_age    = 0;
      m_number = bus.values[m_owner*16 +: 16];
      m_pulse  = 1;
   endtask

   task automatic model_step();
      logic [3:0] r;
      logic [3:0] oth;
      r = bus.req;
      if (rst) begin
         m_owner = 0; m_last = 3; m_busy = 0; m_age = 0;
         m_number = IDLE; m_pulse = 0;
      end else begin
         m_pulse = 0;
         if (!m_busy) begin
            if (r != 4'b0000) m_take(r);
            else              m_number = IDLE;
         end else begin
            if (m_age < 1000) m_age++;
            oth = r & ~(4'b0001 << m_owner);
            if (!r[m_owner]) begin
               if (r != 4'b0000) m_take(r);
               else begin
                  m_busy   = 0;
                  m_number = IDLE;
               end
            end else if (m_age > DWELL && oth != 4'b0000) begin
               m_take(oth);
            end else begin
               m_number = bus.values[m_owner*16 +: 16];
            end
         end
      end
   endtask

   function automatic logic [23:0] m_expect();
      logic [3:0] g;
      g = m_busy ? (4'b0001 << m_owner) : 4'b0000;
      return {g, 2'(m_owner), m_busy, m_number, m_pulse};
   endfunction

   // One clock: the model follows the same edge; outputs are sampled 1 later.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      bus.req = 4'b0000;
      do_reset();
      n_tests++;
      if ({bus.grant, bus.owner, bus.busy, bus.number, bus.switch_pulse} !== {4'b0000, 2'd0, 1'b0, IDLE, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_outputs: got grant=%b owner=%0d busy=%b number=%h pulse=%b, required 0000/0/0/%h/0",
                  bus.grant, bus.owner, bus.busy, bus.number, bus.switch_pulse, IDLE);
      end
   endtask

   task automatic test_single();
      do_reset();
      bus.values[15:0] = 16'h1234;
      bus.req = 4'b0001;
      tick();
      n_tests++;
      if ({bus.grant, bus.number, bus.switch_pulse} !== {4'b0001, 16'h1234, 1'b1}) begin
         n_fail++;
         $display("FAIL single_grant: got grant=%b number=%h pulse=%b, required 0001/1234/1",
                  bus.grant, bus.number, bus.switch_pulse);
      end
      tick();
      n_tests++;
      if (bus.switch_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL single_pulse_width: got pulse=%b, required 0", bus.switch_pulse);
      end
      bus.values[15:0] = 16'hBEEF;
      tick();
      n_tests++;
      if ({bus.grant, bus.number, bus.switch_pulse} !== {4'b0001, 16'hBEEF, 1'b0}) begin
         n_fail++;
         $display("FAIL single_value_update: got grant=%b number=%h pulse=%b, required 0001/beef/0",
                  bus.grant, bus.number, bus.switch_pulse);
      end
   endtask

   task automatic test_dwell();
      logic [3:0] prev;
      logic [3:0] want;
      int         n;
      do_reset();
      bus.values[15:0]  = 16'hAAAA;
      bus.values[47:32] = 16'hCCCC;
      bus.req = 4'b0001;
      tick();
      bus.req = 4'b0101;
      want = 4'b0100;
      for (int sw = 0; sw < 3; sw++) begin
         prev = bus.grant;
         n = 0;
         while (bus.grant === prev && n < 20) begin
            tick();
            n++;
         end
         n_tests++;
         if (n != DWELL + 1 || bus.grant !== want || bus.switch_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL dwell_switch_%0d: got %0d edges grant=%b pulse=%b, required %0d edges grant=%b pulse=1",
                     sw, n, bus.grant, bus.switch_pulse, DWELL + 1, want);
         end
         want = (want == 4'b0100) ? 4'b0001 : 4'b0100;
      end
   endtask

   task automatic test_rr();
      logic [3:0]  exp_g [5];
      logic [15:0] exp_n [5];
      int          n;
      exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
      exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
      exp_n[0] = 16'h1111; exp_n[1] = 16'h2222; exp_n[2] = 16'h3333;
      exp_n[3] = 16'h4444; exp_n[4] = 16'h1111;
      do_reset();
      bus.values = 64'h4444_3333_2222_1111;
      bus.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         n = 0;
         tick();
         while (bus.switch_pulse !== 1'b1 && n < 20) begin
            tick();
            n++;
         end
         n_tests++;
         if (bus.grant !== exp_g[k] || bus.number !== exp_n[k]) begin
            n_fail++;
            $display("FAIL rr_step_%0d: got grant=%b number=%h, required grant=%b number=%h",
                     k, bus.grant, bus.number, exp_g[k], exp_n[k]);
         end
      end
   endtask

   task automatic test_early_release();
      do_reset();
      bus.values = 64'hDDDD_0000_BBBB_0000;
      bus.req = 4'b0010;
      tick();
      bus.req = 4'b1010;
      tick();
      n_tests++;
      if (bus.grant !== 4'b0010) begin
         n_fail++;
         $display("FAIL early_hold_ignores: got grant=%b, required 0010", bus.grant);
      end
      bus.req = 4'b1000;
      tick();
      n_tests++;
      if ({bus.grant, bus.owner, bus.number, bus.switch_pulse} !== {4'b1000, 2'd3, 16'hDDDD, 1'b1}) begin
         n_fail++;
         $display("FAIL early_handover: got grant=%b owner=%0d number=%h pulse=%b, required 1000/3/dddd/1",
                  bus.grant, bus.owner, bus.number, bus.switch_pulse);
      end
      tick();
      n_tests++;
      if (bus.switch_pulse !== 1'b0 || bus.grant !== 4'b1000) begin
         n_fail++;
         $display("FAIL early_single_pulse: got grant=%b pulse=%b, required 1000/0", bus.grant, bus.switch_pulse);
      end
      do_reset();
      bus.req = 4'b0010;
      tick();
      tick();
      bus.req = 4'b0000;
      tick();
      n_tests++;
      if ({bus.grant, bus.owner, bus.busy, bus.number, bus.switch_pulse} !== {4'b0000, 2'd1, 1'b0, IDLE, 1'b0}) begin
         n_fail++;
         $display("FAIL release_to_idle: got grant=%b owner=%0d busy=%b number=%h pulse=%b, required 0000/1/0/%h/0",
                  bus.grant, bus.owner, bus.busy, bus.number, bus.switch_pulse, IDLE);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.values = 64'h0000_9999_0000_7777;
      bus.req = 4'b1010;
      for (int i = 0; i < DWELL + 1; i++) tick();
      rst = 1'b1;
      tick();
      n_tests++;
      if ({bus.grant, bus.owner, bus.busy, bus.number, bus.switch_pulse} !== {4'b0000, 2'd0, 1'b0, IDLE, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: got grant=%b owner=%0d busy=%b number=%h pulse=%b, required 0000/0/0/%h/0",
                  bus.grant, bus.owner, bus.busy, bus.number, bus.switch_pulse, IDLE);
      end
      rst = 1'b0;
      tick();
      n_tests++;
      if (bus.grant !== 4'b0010 || bus.switch_pulse !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_restart: got grant=%b pulse=%b, required 0010/1", bus.grant, bus.switch_pulse);
      end
   endtask

   task automatic test_random();
      logic [23:0] got;
      logic [23:0] want;
      int          bad;
      int          inv_bad;
      int          s;
      do_reset();
      bad = 0;
      inv_bad = 0;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 5) == 0) bus.req[$urandom_range(0, 3)] = ~bus.req[$urandom_range(0, 3)];
         if ($urandom_range(0, 3) == 0) begin
            s = $urandom_range(0, 3);
            bus.values[s*16 +: 16] = 16'($urandom);
         end
         if ($urandom_range(0, 299) == 0) rst = 1'b1;
         tick();
         rst = 1'b0;
         got  = {bus.grant, bus.owner, bus.busy, bus.number, bus.switch_pulse};
         want = m_expect();
         n_tests++;
         if (got !== want) begin
            n_fail++;
            if (bad < 10)
               $display("FAIL random_model c=%0d: got grant=%b owner=%0d busy=%b number=%h pulse=%b, required grant=%b owner=%0d busy=%b number=%h pulse=%b",
                        c, got[23:20], got[19:18], got[17], got[16:1], got[0],
                        want[23:20], want[19:18], want[17], want[16:1], want[0]);
            bad++;
         end
         n_tests++;
         if ($countones(bus.grant) > 1 || bus.busy !== (|bus.grant) ||
             (bus.busy && bus.grant[bus.owner] !== 1'b1)) begin
            n_fail++;
            if (inv_bad < 10)
               $display("FAIL random_invariant c=%0d: got grant=%b busy=%b owner=%0d, required one-hot grant matching busy and owner",
                        c, bus.grant, bus.busy, bus.owner);
            inv_bad++;
         end
      end
   endtask

   initial begin
      rst        = 1'b1;
      bus.req    = 4'b0000;
      bus.values = 64'h0;
      test_reset();
      test_single();
      test_dwell();
      test_rr();
      test_early_release();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
